// File: rtl/dmem_access_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_access_ctrl
//
// Data-memory access controller sitting between pipeline stage Q103H and a
// valid/ready memory port. A load or store presented in Q103H is captured,
// turned into one aligned memory request with byte enables and shifted write
// data, and (for loads) the response is shifted down and sign/zero-extended
// into ld_data_Q104H. A cycle counter aborts requests that never complete.
//
// Build option:
//   DMEM_MISALIGN_TRAP_EN  defined   -> misaligned accesses fault (code 1)
//                                       without touching memory.
//                          undefined -> misaligned accesses are issued with
//                                       byte enables truncated to the word.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid_Q103H     instruction present in Q103H
//   req_rd_en/req_wr_en load / store request
//   req_size            0 byte, 1 half, 2 word, 3 dword
//   req_unsigned        zero-extend loaded data when 1
//   req_addr            byte address
//   req_wr_data         store data, right-aligned
//   ready_Q103H         low stalls Q103H
//   mem_req_valid/ready request handshake
//   mem_addr            word-aligned address
//   mem_wr_data         store data shifted into its byte lanes
//   mem_byte_en         active byte lanes
//   mem_wr_en/mem_rd_en request type
//   mem_rsp_valid/data  read response
//   ld_data_Q104H       extended load result
//   fault, fault_code   0 none, 1 misaligned, 2 timeout, 3 illegal
// ---------------------------------------------------------------------------
module dmem_access_ctrl #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_Q103H,
  input  logic                  req_rd_en,
  input  logic                  req_wr_en,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wr_data,
  output logic                  ready_Q103H,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wr_data,
  output logic [DATA_W/8-1:0]   mem_byte_en,
  output logic                  mem_wr_en,
  output logic                  mem_rd_en,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_W-1:0]     mem_rsp_data,
  output logic [DATA_W-1:0]     ld_data_Q104H,
  output logic                  fault,
  output logic [1:0]            fault_code
);

  localparam int         NB       = DATA_W / 8;
  localparam int         OFF_W    = $clog2(NB);
  localparam logic       DWORD_OK = (DATA_W == 64);
  // Last counter value before the request is abandoned.
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;
  typedef enum logic [1:0] {
    FC_NONE    = 2'd0,
    FC_MISALIGN = 2'd1,
    FC_TIMEOUT = 2'd2,
    FC_ILLEGAL = 2'd3
  } fault_e;

  state_e              state_q, state_d;
  logic                is_wr_q;
  logic [1:0]          size_q;
  logic                unsigned_q;
  logic [OFF_W-1:0]    offset_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wr_data_q;
  logic [NB-1:0]       mem_byte_en_q;
  logic [7:0]          cnt_q;
  logic [DATA_W-1:0]   ld_data_q;
  fault_e              fault_code_q;

  // -------------------------------------------------------------------------
  // Request decode (Q103H inputs, only meaningful in IDLE)
  // -------------------------------------------------------------------------
  logic              accept;
  logic              illegal;
  logic              misalign_trap;
  logic [OFF_W-1:0]  req_offset;
  logic [15:0]       be_mask;
  logic [15:0]       be_shift;

  assign accept     = req_valid_Q103H & (req_rd_en | req_wr_en);
  assign illegal    = (req_rd_en & req_wr_en) | ((req_size == 2'd3) & ~DWORD_OK);
  assign req_offset = req_addr[OFF_W-1:0];

  // Access footprint: 1, 2, 4 or 8 bytes placed at the byte offset; lanes
  // past the end of the word are simply dropped.
  assign be_mask  = (16'd1 << (5'd1 << req_size)) - 16'd1;
  assign be_shift = be_mask << req_offset;

`ifdef DMEM_MISALIGN_TRAP_EN
  logic [3:0] size_mask;
  assign size_mask     = (4'd1 << req_size) - 4'd1;
  assign misalign_trap = |(req_offset & size_mask[OFF_W-1:0]);
`else
  assign misalign_trap = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Load data alignment and extension
  // -------------------------------------------------------------------------
  function automatic logic [DATA_W-1:0] extend_load(
    input logic [DATA_W-1:0] v,
    input logic [1:0]        sz,
    input logic              uns
  );
    logic [DATA_W-1:0] r;
    int                nbits;
    nbits = 8 << sz;
    if (nbits > DATA_W) nbits = DATA_W;
    for (int i = 0; i < DATA_W; i++) begin
      r[i] = (i < nbits) ? v[i] : (~uns & v[nbits-1]);
    end
    return r;
  endfunction

  logic [DATA_W-1:0] rsp_shifted;
  assign rsp_shifted = mem_rsp_data >> {offset_q, 3'b000};

  // -------------------------------------------------------------------------
  // FSM next state and handshake outputs
  // -------------------------------------------------------------------------
  logic timeout_hit;
  logic timeout_fire;

  assign timeout_hit = (cnt_q >= TO_LAST);

  // NOTE: every signal assigned in this block gets a default first so that no
  // path through the case statement leaves it unassigned and infers a latch.
  always_comb begin
    state_d      = state_q;
    ready_Q103H  = 1'b0;
    timeout_fire = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Any captured request (including one that faults immediately)
        // stalls the stage until DONE releases it.
        ready_Q103H = ~accept;
        if (accept) state_d = (illegal | misalign_trap) ? DONE : REQ;
      end
      REQ: begin
        if (mem_req_ready) begin
          state_d = is_wr_q ? DONE : WAIT;
        end else if (timeout_hit) begin
          state_d      = DONE;
          timeout_fire = 1'b1;
        end
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          state_d = DONE;
        end else if (timeout_hit) begin
          state_d      = DONE;
          timeout_fire = 1'b1;
        end
      end
      DONE: begin
        ready_Q103H = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // Request capture, counter, load result and fault status
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_wr_q       <= 1'b0;
      size_q        <= 2'd0;
      unsigned_q    <= 1'b0;
      offset_q      <= '0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      mem_byte_en_q <= '0;
      cnt_q         <= 8'd0;
      ld_data_q     <= '0;
      fault_code_q  <= FC_NONE;
    end else begin
      if (state_q == IDLE && accept) begin
        is_wr_q       <= req_wr_en;
        size_q        <= req_size;
        unsigned_q    <= req_unsigned;
        offset_q      <= req_offset;
        mem_addr_q    <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        mem_wr_data_q <= req_wr_data << {req_offset, 3'b000};
        mem_byte_en_q <= be_shift[NB-1:0];
        cnt_q         <= 8'd0;
        fault_code_q  <= illegal       ? FC_ILLEGAL  :
                         misalign_trap ? FC_MISALIGN : FC_NONE;
      end

      if (state_q == REQ || state_q == WAIT) cnt_q <= cnt_q + 8'd1;

      if (state_q == WAIT && mem_rsp_valid) begin
        ld_data_q <= extend_load(rsp_shifted, size_q, unsigned_q);
      end else if (timeout_fire) begin
        ld_data_q    <= '0;
        fault_code_q <= FC_TIMEOUT;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign mem_req_valid = (state_q == REQ);
  assign mem_wr_en     = (state_q == REQ) & is_wr_q;
  assign mem_rd_en     = (state_q == REQ) & ~is_wr_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wr_data   = mem_wr_data_q;
  assign mem_byte_en   = mem_byte_en_q;
  assign ld_data_Q104H = ld_data_q;
  assign fault_code    = fault_code_q;
  assign fault         = (state_q == DONE) & (fault_code_q != FC_NONE);

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dmem_access_ctrl
//
// Directed bench for dmem_access_ctrl (DATA_W=32, TIMEOUT_CYC=4). The bench
// plays the pipeline and the memory: it drives inputs one time unit after
// each rising edge and samples outputs in the same window, away from the edge.
// ---------------------------------------------------------------------------
module tb_dmem_access_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid_Q103H = 1'b0;
  logic              req_rd_en = 1'b0;
  logic              req_wr_en = 1'b0;
  logic [1:0]        req_size = 2'd0;
  logic              req_unsigned = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wr_data = '0;
  logic              ready_Q103H;
  logic              mem_req_valid;
  logic              mem_req_ready = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic [3:0]        mem_byte_en;
  logic              mem_wr_en;
  logic              mem_rd_en;
  logic              mem_rsp_valid = 1'b0;
  logic [DATA_W-1:0] mem_rsp_data = '0;
  logic [DATA_W-1:0] ld_data_Q104H;
  logic              fault;
  logic [1:0]        fault_code;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_access_ctrl #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .TIMEOUT_CYC(4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid_Q103H(req_valid_Q103H),
    .req_rd_en      (req_rd_en),
    .req_wr_en      (req_wr_en),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .req_addr       (req_addr),
    .req_wr_data    (req_wr_data),
    .ready_Q103H    (ready_Q103H),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_wr_data    (mem_wr_data),
    .mem_byte_en    (mem_byte_en),
    .mem_wr_en      (mem_wr_en),
    .mem_rd_en      (mem_rd_en),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .ld_data_Q104H  (ld_data_Q104H),
    .fault          (fault),
    .fault_code     (fault_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wd);
    req_valid_Q103H = 1'b1;
    req_rd_en       = rd;
    req_wr_en       = wr;
    req_size        = sz;
    req_unsigned    = uns;
    req_addr        = addr;
    req_wr_data     = wd;
  endtask

  task automatic idle_req();
    req_valid_Q103H = 1'b0;
    req_rd_en       = 1'b0;
    req_wr_en       = 1'b0;
  endtask

  // Load with memory ready immediately and the response one cycle later:
  // issue in cycle N, REQ in N+1, WAIT in N+2, DONE in N+3.
  task automatic do_load(input string tag, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] rsp,
                         input logic [3:0] exp_be, input logic [31:0] exp_addr,
                         input logic [31:0] exp_ld);
    issue(1'b1, 1'b0, sz, uns, addr, 32'h0);
    mem_req_ready = 1'b1;
    #1;
    check({tag, ".ready_drop"}, ready_Q103H, 1'b0);
    tick();                                   // N+1: REQ
    idle_req();
    check({tag, ".req_valid"}, mem_req_valid, 1'b1);
    check({tag, ".rd_en"}, mem_rd_en, 1'b1);
    check({tag, ".addr"}, mem_addr, exp_addr);
    check({tag, ".byte_en"}, mem_byte_en, exp_be);
    tick();                                   // N+2: WAIT
    check({tag, ".wait_ready"}, ready_Q103H, 1'b0);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = rsp;
    tick();                                   // N+3: DONE
    mem_rsp_valid = 1'b0;
    check({tag, ".done_ready"}, ready_Q103H, 1'b1);
    check({tag, ".ld_data"}, ld_data_Q104H, exp_ld);
    check({tag, ".fault"}, fault, 1'b0);
    check({tag, ".fault_code"}, fault_code, 2'd0);
    tick();                                   // back in IDLE
    check({tag, ".ld_hold"}, ld_data_Q104H, exp_ld);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- reset state ----------------
    #3;
    check("rst.ready", ready_Q103H, 1'b1);
    check("rst.mem_req_valid", mem_req_valid, 1'b0);
    check("rst.mem_addr", mem_addr, 32'h0);
    check("rst.byte_en", mem_byte_en, 4'h0);
    check("rst.wr_rd_en", {mem_wr_en, mem_rd_en}, 2'b00);
    check("rst.wr_data", mem_wr_data, 32'h0);
    check("rst.ld_data", ld_data_Q104H, 32'h0);
    check("rst.fault", {fault, fault_code}, 3'b000);
    #9 rst_n = 1'b1;
    tick();

    // ---------------- loads ----------------
    do_load("ld_w104",  2'd2, 1'b0, 32'h104, 32'hDEADBEEF, 4'hF, 32'h104, 32'hDEADBEEF);
    do_load("ld_bs103", 2'd0, 1'b0, 32'h103, 32'h80000000, 4'h8, 32'h100, 32'hFFFFFF80);
    do_load("ld_bu103", 2'd0, 1'b1, 32'h103, 32'h80000000, 4'h8, 32'h100, 32'h00000080);
    do_load("ld_hs102", 2'd1, 1'b0, 32'h102, 32'hABCD1234, 4'hC, 32'h100, 32'hFFFFABCD);
    do_load("ld_hu106", 2'd1, 1'b1, 32'h106, 32'h12348765, 4'hC, 32'h104, 32'h00001234);
    do_load("ld_bs101", 2'd0, 1'b0, 32'h101, 32'h00007F00, 4'h2, 32'h100, 32'h0000007F);

    // ---------------- store half, memory busy 3 cycles ----------------
    issue(1'b0, 1'b1, 2'd1, 1'b0, 32'h102, 32'h00001234);
    mem_req_ready = 1'b0;
    tick();
    idle_req();
    for (int i = 0; i < 3; i++) begin
      check("st_h.req_valid", mem_req_valid, 1'b1);
      check("st_h.wr_en", mem_wr_en, 1'b1);
      check("st_h.addr", mem_addr, 32'h100);
      check("st_h.byte_en", mem_byte_en, 4'hC);
      check("st_h.wr_data", mem_wr_data, 32'h12340000);
      check("st_h.ready", ready_Q103H, 1'b0);
      tick();
    end
    check("st_h.req_valid4", mem_req_valid, 1'b1);
    mem_req_ready = 1'b1;
    tick();
    check("st_h.done_ready", ready_Q103H, 1'b1);
    check("st_h.done_fault", {fault, fault_code}, 3'b000);
    check("st_h.ld_untouched", ld_data_Q104H, 32'h0000007F);
    tick();

    // ---------------- load timeout, late response ----------------
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h200, 32'h0);
    mem_req_ready = 1'b1;
    tick();                                   // REQ, handshake
    idle_req();
    check("to_ld.req_valid", mem_req_valid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();                                 // WAIT x3
      check("to_ld.wait_ready", ready_Q103H, 1'b0);
    end
    tick();                                   // DONE after 4 counted cycles
    check("to_ld.done_ready", ready_Q103H, 1'b1);
    check("to_ld.fault", fault, 1'b1);
    check("to_ld.fault_code", fault_code, 2'd2);
    check("to_ld.ld_zero", ld_data_Q104H, 32'h0);
    tick();                                   // IDLE
    check("to_ld.fault_clr", fault, 1'b0);
    check("to_ld.code_hold", fault_code, 2'd2);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h55AA55AA;
    tick();
    mem_rsp_valid = 1'b0;
    check("to_ld.late_ignored", ld_data_Q104H, 32'h0);
    check("to_ld.idle_ready", ready_Q103H, 1'b1);
    check("to_ld.no_req", mem_req_valid, 1'b0);

    // ---------------- store timeout, memory never ready ----------------
    issue(1'b0, 1'b1, 2'd2, 1'b0, 32'h208, 32'hCAFEF00D);
    mem_req_ready = 1'b0;
    tick();
    idle_req();
    check("to_st.code_clr", fault_code, 2'd0);
    check("to_st.wr_data", mem_wr_data, 32'hCAFEF00D);
    check("to_st.byte_en", mem_byte_en, 4'hF);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("to_st.req_valid", mem_req_valid, 1'b1);
    end
    tick();
    check("to_st.req_drop", mem_req_valid, 1'b0);
    check("to_st.done_ready", ready_Q103H, 1'b1);
    check("to_st.fault", {fault, fault_code}, 3'b110);
    tick();
    mem_req_ready = 1'b1;

    // ---------------- illegal: rd and wr together ----------------
    issue(1'b1, 1'b1, 2'd2, 1'b0, 32'h300, 32'h0);
    tick();
    idle_req();
    check("ill_rw.req_valid", mem_req_valid, 1'b0);
    check("ill_rw.done_ready", ready_Q103H, 1'b1);
    check("ill_rw.fault", {fault, fault_code}, 3'b111);
    tick();
    check("ill_rw.code_hold", {fault, fault_code}, 3'b011);

    // ---------------- illegal: dword on 32-bit memory ----------------
    issue(1'b1, 1'b0, 2'd3, 1'b0, 32'h308, 32'h0);
    tick();
    idle_req();
    check("ill_dw.req_valid", mem_req_valid, 1'b0);
    check("ill_dw.fault", {fault, fault_code}, 3'b111);
    tick();

    // ---------------- misaligned word at 0x101 ----------------
`ifdef DMEM_MISALIGN_TRAP_EN
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h101, 32'h0);
    tick();
    idle_req();
    check("mis_w.req_valid", mem_req_valid, 1'b0);
    check("mis_w.done_ready", ready_Q103H, 1'b1);
    check("mis_w.fault", {fault, fault_code}, 3'b101);
    tick();
    check("mis_w.idle_req", mem_req_valid, 1'b0);
`else
    do_load("mis_w", 2'd2, 1'b0, 32'h101, 32'h11223344, 4'hE, 32'h100, 32'h00112233);
`endif

    // ---------------- reset while waiting for a response ----------------
    do_load("pre_rst", 2'd2, 1'b0, 32'h104, 32'h0BADF00D, 4'hF, 32'h104, 32'h0BADF00D);
    issue(1'b1, 1'b1, 2'd2, 1'b0, 32'h300, 32'h0);   // leave fault_code = 3
    tick();
    idle_req();
    tick();
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h10C, 32'h0);
    tick();                                   // REQ
    idle_req();
    tick();                                   // WAIT
    check("rst_mid.in_wait", ready_Q103H, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_mid.ready", ready_Q103H, 1'b1);
    check("rst_mid.mem_addr", mem_addr, 32'h0);
    check("rst_mid.byte_en", mem_byte_en, 4'h0);
    check("rst_mid.ld_data", ld_data_Q104H, 32'h0);
    check("rst_mid.fault_code", fault_code, 2'd0);
    #2 rst_n = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hFFFFFFFF;
    tick();
    mem_rsp_valid = 1'b0;
    check("rst_mid.rsp_dropped", ld_data_Q104H, 32'h0);
    check("rst_mid.idle_ready", ready_Q103H, 1'b1);
    do_load("post_rst", 2'd0, 1'b1, 32'h100, 32'h000000C3, 4'h1, 32'h100, 32'h000000C3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, memory data width (32 or 64); ADDR_W, default 32, address width; TIMEOUT_CYC, default 255, max wait cycles (1..255).
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req_valid_Q103H  in  1  instruction present in Q103H.
REQ-005 req_rd_en / req_wr_en  in  1 each  load / store request.
REQ-006 req_size  in  2  0 byte, 1 half, 2 word, 3 dword.
REQ-007 req_unsigned  in  1  zero-extend load when 1.
REQ-008 req_addr  in  ADDR_W  byte address.
REQ-009 req_wr_data  in  DATA_W  store data, right-aligned.
REQ-010 ready_Q103H  out  1  low stalls Q103H.
REQ-011 mem_req_valid / mem_req_ready  out / in  1 each  request handshake.
REQ-012 mem_addr  out  ADDR_W  aligned address; mem_wr_data  out  DATA_W; mem_byte_en  out  DATA_W/8; mem_wr_en, mem_rd_en  out  1 each.
REQ-013 mem_rsp_valid / mem_rsp_data  in  1 / DATA_W  read response.
REQ-014 ld_data_Q104H  out  DATA_W  extended load result.
REQ-015 fault  out  1; fault_code  out  2  (0 none, 1 misaligned, 2 timeout, 3 illegal).

Function
REQ-016 FSM states SHALL be IDLE, REQ, WAIT, DONE.
REQ-017 IDLE: if req_valid_Q103H and exactly one of rd/wr, capture request, drop ready_Q103H combinationally, go REQ; else ready_Q103H=1, stay IDLE.
REQ-018 rd and wr both set, or req_size=3 with DATA_W=32, SHALL go IDLE->DONE with fault_code=3, no memory request.
REQ-019 REQ: mem_req_valid=1 with all mem_* stable until mem_req_ready; on handshake store->DONE, load->WAIT.
REQ-020 WAIT: on mem_rsp_valid capture data, go DONE; rsp_valid outside WAIT SHALL be ignored.
REQ-021 DONE: ready_Q103H=1 for exactly one cycle, fault=1 if fault_code!=0, req inputs ignored, next state IDLE.
REQ-022 Load latency with mem_req_ready=1 and response next cycle: request cycle N, DONE at N+3.
REQ-023 mem_addr SHALL be req_addr with low log2(DATA_W/8) bits cleared; offset = those bits.
REQ-024 mem_byte_en = ((1<<(1<<size))-1) << offset, truncated to DATA_W/8 bits; mem_wr_data = req_wr_data << (8*offset).
REQ-025 ld_data_Q104H = (rsp_data >> 8*offset) sign- or zero-extended from size; valid from DONE, held until next load completes.
REQ-026 Counter SHALL count cycles in REQ+WAIT; reaching TIMEOUT_CYC -> DONE, fault_code=2, ld_data_Q104H=0, mem_req_valid deasserts.
REQ-027 fault_code SHALL hold until next request captured.

Reset
REQ-028 rst_n low SHALL force IDLE, counter 0, ld_data_Q104H 0, fault 0, fault_code 0, all mem_* outputs 0, ready_Q103H per IDLE rule.
REQ-029 Reset mid-operation SHALL abandon the transaction; any later response is dropped in IDLE.

Configuration
REQ-030 DMEM_MISALIGN_TRAP_EN defined: offset not multiple of (1<<size) SHALL go IDLE->DONE, fault_code=1, no memory request.
REQ-031 DMEM_MISALIGN_TRAP_EN undefined: misaligned access SHALL issue with byte enables truncated per REQ-024, no fault.

Verification
REQ-032 Load word addr 0x104, rsp 0xDEADBEEF next cycle -> byte_en 0xF, mem_addr 0x104, ld_data 0xDEADBEEF, DONE at N+3.
REQ-033 Load byte signed addr 0x103, rsp 0x80000000 -> byte_en 0x8, ld_data 0xFFFFFF80; unsigned -> 0x00000080.
REQ-034 Store half addr 0x102 data 0x1234 with mem_req_ready low 3 cycles -> mem_* stable, byte_en 0xC, wr_data 0x12340000, ready low until DONE.
REQ-035 TIMEOUT_CYC=4, load never answered -> DONE after 4 cycles, fault=1, fault_code=2, ld_data 0; late rsp ignored.
REQ-036 Load word addr 0x101: trap build -> fault_code=1, no mem_req_valid; non-trap build -> byte_en 0xE, no fault; rst_n pulse in WAIT -> IDLE, outputs 0.
